pe_scheduler: RTL and testbench
===============================

PE_SCHEDULER -- requirements
Module: pe_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, meaning PE data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning source-memory address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 5, meaning row and filter length counter width.
REQ-004 SHALL have parameter ROWS_WIDTH, default 6, meaning row counter width.
REQ-005 SHALL have ports clk (input, 1, single clock, rising edge) and rst (input, 1, asynchronous active-low reset).
REQ-006 SHALL have ports go (input, 1, job start pulse), busy (output, 1, job in progress) and done_all (output, 1, one-cycle job-complete pulse).
REQ-007 SHALL have inputs cfg_row_len (LEN_WIDTH, IFMap elements per row, ≥1), cfg_filter_len (LEN_WIDTH, filter elements, ≥1) and cfg_num_rows (ROWS_WIDTH, rows per job, ≥1).
REQ-008 SHALL have ports ifmap_raddr (output, ADDR_WIDTH), ifmap_rdata (input, DATA_WIDTH), filter_raddr (output, ADDR_WIDTH) and filter_rdata (input, DATA_WIDTH); both memories are synchronous read with 1-cycle latency.
REQ-009 SHALL have ports wen_IFMap (output, 1), IFMap_in (output, DATA_WIDTH+2, {tag[1:0],data}) and ready_IFMap (input, 1, IFMap buffer not full).
REQ-010 SHALL have ports wen_Filter (output, 1), Filter_in (output, DATA_WIDTH) and ready_Filter (input, 1, Filter buffer not full).
REQ-011 SHALL have ports pe_start (output, 1, PE Start pulse), pe_ready (input, 1, PE idle) and pe_done (input, 1, PE row-complete pulse).
REQ-012 SHALL have port cycle_count (output, 32, busy-cycle count).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_FILT, LOAD_IFMAP, START, WAIT_DONE, FINISH.
REQ-014 IDLE: go=1 SHALL latch cfg_* inputs, clear both read addresses to 0 and the row counter, and go to LOAD_FILT; go SHALL be ignored in every other state.
REQ-015 Each load element SHALL take a read phase (drive address) and then a write phase; in the write phase the block SHALL assert wen_* only while the matching ready_* is 1, holding data stable otherwise; the address SHALL increment by 1 only on an accepted write (wen=1).
REQ-016 LOAD_FILT SHALL write cfg_filter_len elements once per job, Filter_in=filter_rdata, then go to LOAD_IFMAP.
REQ-017 LOAD_IFMAP SHALL write cfg_row_len elements with tag 2'b10 on the first, 2'b01 on the last, 2'b11 when cfg_row_len=1, and 2'b00 otherwise, then go to START.
REQ-018 ifmap_raddr SHALL continue across rows with no reset between rows.
REQ-019 START SHALL wait for pe_ready=1, assert pe_start for exactly one cycle and go to WAIT_DONE.
REQ-020 WAIT_DONE on pe_done=1 SHALL increment the row counter; if it equals cfg_num_rows it SHALL go to FINISH, else to LOAD_IFMAP.
REQ-021 A pe_done outside WAIT_DONE SHALL be ignored.
REQ-022 FINISH SHALL pulse done_all for one cycle and return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 A cfg_* change while busy SHALL have no effect on the current job.

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE and set busy, done_all, wen_IFMap, wen_Filter and pe_start to 0, IFMap_in, Filter_in, ifmap_raddr and filter_raddr to 0, counters to 0, and cycle_count to 0.
REQ-026 Reset mid-job SHALL abort the job without a done_all pulse; buffer contents are not the block's responsibility.

Configuration
REQ-027 With macro PE_SCHED_PERF_EN defined, cycle_count SHALL clear on an accepted go and increment each cycle busy=1, saturating at all-ones.
REQ-028 Without PE_SCHED_PERF_EN, cycle_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-029 Filter len 5, row len 10, rows 1, ready always 1 -> 5 filter writes, then 10 IFMap writes with tags 10,00×8,01, one pe_start, done_all one cycle after pe_done.
REQ-030 Rows 3, row len 4 -> ifmap_raddr covers 0..11 contiguously, 3 pe_start pulses, each after the prior pe_done, a single filter load, a single done_all.
REQ-031 ready_IFMap low for 7 cycles mid-row -> no wen_IFMap while low, IFMap_in held, no element lost or duplicated.
REQ-032 cfg_row_len=1 -> single write with tag 2'b11.
REQ-033 rst low during WAIT_DONE of row 2 -> all outputs 0 immediately, no done_all, and a new go restarts at address 0.
REQ-034 With PE_SCHED_PERF_EN, cycle_count SHALL equal the number of busy cycles; without it, cycle_count SHALL stay 0.

Source files
------------

// File: rtl/pe_scheduler.sv
// Sequences filter and IFMap loads from source memories into the PE buffers and runs one PE pass per row.
// Define PE_SCHED_PERF_EN to build the saturating busy-cycle counter on cycle_count.
module pe_scheduler #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 5,
  parameter int ROWS_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  output logic                    busy,
  output logic                    done_all,
  input  logic [LEN_WIDTH-1:0]    cfg_row_len,
  input  logic [LEN_WIDTH-1:0]    cfg_filter_len,
  input  logic [ROWS_WIDTH-1:0]   cfg_num_rows,
  output logic [ADDR_WIDTH-1:0]   ifmap_raddr,
  input  logic [DATA_WIDTH-1:0]   ifmap_rdata,
  output logic [ADDR_WIDTH-1:0]   filter_raddr,
  input  logic [DATA_WIDTH-1:0]   filter_rdata,
  output logic                    wen_IFMap,
  output logic [DATA_WIDTH+1:0]   IFMap_in,
  input  logic                    ready_IFMap,
  output logic                    wen_Filter,
  output logic [DATA_WIDTH-1:0]   Filter_in,
  input  logic                    ready_Filter,
  output logic                    pe_start,
  input  logic                    pe_ready,
  input  logic                    pe_done,
  output logic [31:0]             cycle_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD_FILT, LOAD_IFMAP, START, WAIT_DONE, FINISH
  } state_t;

  state_t                  r_state;
  logic                    r_phase;
  logic [LEN_WIDTH-1:0]    r_row_len;
  logic [LEN_WIDTH-1:0]    r_filt_len;
  logic [LEN_WIDTH-1:0]    r_elem_cnt;
  logic [ROWS_WIDTH-1:0]   r_num_rows;
  logic [ROWS_WIDTH-1:0]   r_row_cnt;
  logic [ADDR_WIDTH-1:0]   r_ifmap_addr;
  logic [ADDR_WIDTH-1:0]   r_filt_addr;
  logic                    r_pe_start;
  logic                    r_done_all;

  logic                    w_filt_wr;
  logic                    w_if_wr;
  logic                    w_first;
  logic                    w_filt_last;
  logic                    w_if_last;
  logic [ROWS_WIDTH-1:0]   w_row_next;

  // r_phase=0 drives the address, r_phase=1 is the write phase with read data valid.
  assign w_filt_wr   = (r_state == LOAD_FILT)  && r_phase;
  assign w_if_wr     = (r_state == LOAD_IFMAP) && r_phase;
  assign w_first     = (r_elem_cnt == '0);
  assign w_filt_last = (r_elem_cnt == (r_filt_len - LEN_WIDTH'(1)));
  assign w_if_last   = (r_elem_cnt == (r_row_len - LEN_WIDTH'(1)));
  assign w_row_next  = r_row_cnt + ROWS_WIDTH'(1);

  assign busy         = (r_state != IDLE);
  assign done_all     = r_done_all;
  assign pe_start     = r_pe_start;
  assign ifmap_raddr  = r_ifmap_addr;
  assign filter_raddr = r_filt_addr;
  assign wen_Filter   = w_filt_wr && ready_Filter;
  assign wen_IFMap    = w_if_wr && ready_IFMap;
  assign Filter_in    = w_filt_wr ? filter_rdata : '0;
  assign IFMap_in     = w_if_wr ? {w_first, w_if_last, ifmap_rdata} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_phase      <= 1'b0;
      r_row_len    <= '0;
      r_filt_len   <= '0;
      r_num_rows   <= '0;
      r_elem_cnt   <= '0;
      r_row_cnt    <= '0;
      r_ifmap_addr <= '0;
      r_filt_addr  <= '0;
      r_pe_start   <= 1'b0;
      r_done_all   <= 1'b0;
    end else begin
      r_pe_start <= 1'b0;
      r_done_all <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_row_len    <= cfg_row_len;
            r_filt_len   <= cfg_filter_len;
            r_num_rows   <= cfg_num_rows;
            r_elem_cnt   <= '0;
            r_row_cnt    <= '0;
            r_ifmap_addr <= '0;
            r_filt_addr  <= '0;
            r_phase      <= 1'b0;
            r_state      <= LOAD_FILT;
          end
        end
        LOAD_FILT: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else if (ready_Filter) begin
            r_filt_addr <= r_filt_addr + ADDR_WIDTH'(1);
            r_phase     <= 1'b0;
            if (w_filt_last) begin
              r_elem_cnt <= '0;
              r_state    <= LOAD_IFMAP;
            end else begin
              r_elem_cnt <= r_elem_cnt + LEN_WIDTH'(1);
            end
          end
        end
        LOAD_IFMAP: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else if (ready_IFMap) begin
            r_ifmap_addr <= r_ifmap_addr + ADDR_WIDTH'(1);
            r_phase      <= 1'b0;
            if (w_if_last) begin
              r_elem_cnt <= '0;
              r_state    <= START;
            end else begin
              r_elem_cnt <= r_elem_cnt + LEN_WIDTH'(1);
            end
          end
        end
        START: begin
          if (pe_ready) begin
            r_pe_start <= 1'b1;
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (pe_done) begin
            r_row_cnt <= w_row_next;
            if (w_row_next == r_num_rows) begin
              r_done_all <= 1'b1;
              r_state    <= FINISH;
            end else begin
              r_phase <= 1'b0;
              r_state <= LOAD_IFMAP;
            end
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PE_SCHED_PERF_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_count <= '0;
    end else if ((r_state == IDLE) && go) begin
      r_cycle_count <= '0;
    end else if (busy && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// Directed bench for pe_scheduler: memory and PE models, a negedge write monitor and per-job count checks.
module tb_pe_scheduler;
  localparam int DW = 20;
  localparam int AW = 8;
  localparam int LW = 5;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic          busy;
  logic          done_all;
  logic [LW-1:0] cfg_row_len;
  logic [LW-1:0] cfg_filter_len;
  logic [RW-1:0] cfg_num_rows;
  logic [AW-1:0] ifmap_raddr;
  logic [DW-1:0] ifmap_rdata;
  logic [AW-1:0] filter_raddr;
  logic [DW-1:0] filter_rdata;
  logic          wen_IFMap;
  logic [DW+1:0] IFMap_in;
  logic          ready_IFMap;
  logic          wen_Filter;
  logic [DW-1:0] Filter_in;
  logic          ready_Filter;
  logic          pe_start;
  logic          pe_ready;
  logic          pe_done;
  logic [31:0]   cycle_count;

  int totalChecks = 0;
  int badChecks = 0;
  int nf = 0;
  int ni = 0;
  int startCnt = 0;
  int doneCnt = 0;
  int doneAllCnt = 0;
  int busyCycles = 0;
  int curRowLen = 1;
  int curFiltLen = 1;
  logic prevPeDone = 1'b0;

  always #5 clk = ~clk;

  pe_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ROWS_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done_all(done_all),
    .cfg_row_len(cfg_row_len), .cfg_filter_len(cfg_filter_len), .cfg_num_rows(cfg_num_rows),
    .ifmap_raddr(ifmap_raddr), .ifmap_rdata(ifmap_rdata),
    .filter_raddr(filter_raddr), .filter_rdata(filter_rdata),
    .wen_IFMap(wen_IFMap), .IFMap_in(IFMap_in), .ready_IFMap(ready_IFMap),
    .wen_Filter(wen_Filter), .Filter_in(Filter_in), .ready_Filter(ready_Filter),
    .pe_start(pe_start), .pe_ready(pe_ready), .pe_done(pe_done),
    .cycle_count(cycle_count)
  );

  // Source memories: word at address a is 0x01000+a (IFMap) or 0x02000+a (filter), one-cycle read latency.
  always @(posedge clk) begin
    ifmap_rdata  <= 20'h01000 + 20'(ifmap_raddr);
    filter_rdata <= 20'h02000 + 20'(filter_raddr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] expTag(input int idx, input int len);
    expTag = {(idx % len) == 0, (idx % len) == (len - 1)};
  endfunction

  // PE model: busy for four cycles after each start, then a one-cycle done.
  initial begin
    pe_done  = 1'b0;
    pe_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (pe_start) begin
        pe_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 pe_done = 1'b1;
        doneCnt++;
        @(posedge clk);
        #1 pe_done = 1'b0;
        pe_ready = 1'b1;
      end
    end
  end

  // Write monitor: every accepted word must be the next expected address with the right tag.
  always @(negedge clk) begin
    if (wen_Filter) begin
      checkOutput("filt_data", 32'(Filter_in), 32'h2000 + 32'(nf));
      nf++;
    end
    if (wen_IFMap) begin
      checkOutput("filt_before_ifmap", 32'(nf), 32'(curFiltLen));
      checkOutput("ifmap_word", 32'(IFMap_in), {10'b0, expTag(ni, curRowLen), 20'h01000 + 20'(ni)});
      ni++;
    end
    if (!ready_IFMap) checkOutput("wen_while_full", 32'(wen_IFMap), 32'd0);
    if (pe_start) begin
      checkOutput("start_order", 32'(startCnt), 32'(doneCnt));
      startCnt++;
    end
    if (done_all) begin
      checkOutput("done_latency", 32'(prevPeDone), 32'd1);
      doneAllCnt++;
    end
    if (busy) busyCycles++;
    prevPeDone = pe_done;
  end

  task automatic applyStimulus(input int f, input int r, input int n);
    @(posedge clk);
    #1;
    cfg_filter_len = LW'(f);
    cfg_row_len    = LW'(r);
    cfg_num_rows   = RW'(n);
    curFiltLen = f;
    curRowLen  = r;
    nf = 0; ni = 0; startCnt = 0; doneCnt = 0; doneAllCnt = 0; busyCycles = 0;
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic finishJob(input int f, input int r, input int n);
    int k;
    k = 0;
    while (doneAllCnt == 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    checkOutput("done_seen", 32'(doneAllCnt > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("filt_count", 32'(nf), 32'(f));
    checkOutput("ifmap_count", 32'(ni), 32'(r * n));
    checkOutput("start_count", 32'(startCnt), 32'(n));
    checkOutput("done_all_count", 32'(doneAllCnt), 32'd1);
    checkOutput("busy_after", 32'(busy), 32'd0);
`ifdef PE_SCHED_PERF_EN
    checkOutput("cycle_count", cycle_count, 32'(busyCycles));
`else
    checkOutput("cycle_count", cycle_count, 32'd0);
`endif
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_all", 32'(done_all), 32'd0);
    checkOutput("rst_wen", {30'd0, wen_IFMap, wen_Filter}, 32'd0);
    checkOutput("rst_pe_start", 32'(pe_start), 32'd0);
    checkOutput("rst_ifmap_in", 32'(IFMap_in), 32'd0);
    checkOutput("rst_filter_in", 32'(Filter_in), 32'd0);
    checkOutput("rst_addrs", {16'd0, ifmap_raddr, filter_raddr}, 32'd0);
    checkOutput("rst_cycle_count", cycle_count, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b0; go = 1'b0;
    ready_IFMap = 1'b1; ready_Filter = 1'b1;
    cfg_row_len = '0; cfg_filter_len = '0; cfg_num_rows = '0;
    #2;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] job 1: filter 5, row 10, 1 row");
    applyStimulus(5, 10, 1);
    finishJob(5, 10, 1);

    $display("[TB] job 2: filter 1, row 4, 3 rows, with a stray go and cfg change mid-job");
    applyStimulus(1, 4, 3);
    repeat (3) @(posedge clk);
    #1;
    cfg_filter_len = LW'(3); cfg_row_len = LW'(2); cfg_num_rows = RW'(1);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    finishJob(1, 4, 3);

    $display("[TB] job 3: IFMap buffer full for 7 cycles mid-row");
    applyStimulus(2, 10, 1);
    k = 0;
    while (ni < 5 && k < 500) begin
      @(posedge clk);
      k++;
    end
    checkOutput("stall_reached", 32'(ni), 32'd5);
    #1 ready_IFMap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (i >= 1) checkOutput("stall_hold", 32'(IFMap_in), {10'b0, 2'b00, 20'h01005});
    end
    ready_IFMap = 1'b1;
    finishJob(2, 10, 1);

    $display("[TB] job 4: row length 1, 2 rows");
    applyStimulus(1, 1, 2);
    finishJob(1, 1, 2);

    $display("[TB] job 5: reset during second row's PE pass");
    applyStimulus(2, 4, 3);
    k = 0;
    while (startCnt < 2 && k < 500) begin
      @(posedge clk);
      k++;
    end
    checkOutput("second_start", 32'(startCnt), 32'd2);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkResetOutputs();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no_done_after_abort", 32'(doneAllCnt), 32'd0);
    checkOutput("busy_in_reset", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] job 6: restart after abort");
    applyStimulus(1, 2, 1);
    finishJob(1, 2, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
